sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Bus-side controller sitting directly upstream of the 64K x 16 asynchronous SRAM (CY7C1021-class) on the system memory path.
- Accepts 32-bit word read/write requests with byte strobes from the core bus.
- Splits each request into two sequenced 16-bit SRAM accesses (low half, then high half), driving CE/OE/WE/BLE/BHE and the bidirectional data bus.
- Returns a one-cycle acknowledge with assembled read data.

Parameters:
- WAIT_CYCLES, 0, extra setup cycles inserted per half-access (0..7).
- ADDR_W, 17, byte-address width (128 KiB, 64K halfwords).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request valid; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; latched with req.
- addr  input  ADDR_W  byte address; addr[1:0] ignored (word aligned).
- wdata  input  32  write data; little-endian, byte0 = wdata[7:0].
- wstrb  input  4  byte write enables, active-high.
- rdata  output  32  read data; valid in the ack cycle, held until next read ack.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state is not IDLE.
- sram_ce_n  output  1  chip enable, active low.
- sram_oe_n  output  1  output enable, active low.
- sram_we_n  output  1  write enable, active low.
- sram_ble_n  output  1  low byte enable, active low.
- sram_bhe_n  output  1  high byte enable, active low.
- sram_a  output  16  halfword address.
- sram_io  inout  16  data bus; driven only during write phases, else high-Z.

Behaviour:
- Reset (async, any state):
  - state = IDLE; ack = 0; busy = 0; rdata = 0.
  - All sram_*_n = 1; sram_a = 0; sram_io released to high-Z.
  - An in-flight access is aborted: no ack, partial writes are not undone.
- States: IDLE, LO, HI, DONE. A wait counter (3 bits) runs within LO and HI.
- IDLE:
  - On req=1, latch wr, addr[ADDR_W-1:2], wdata, wstrb.
  - Next state:
    - LO if read, or if wstrb[1:0] != 0.
    - Otherwise HI if wstrb[3:2] != 0.
    - Otherwise DONE (zero-strobe write produces no SRAM activity).
- LO and HI phases:
  - Each lasts WAIT_CYCLES+1 cycles.
  - sram_a = {word_addr, 0} in LO and {word_addr, 1} in HI.
  - sram_ce_n = 0 throughout the phase.
- Read phase:
  - sram_oe_n = 0 and sram_we_n = 1 throughout.
  - ble_n = bhe_n = 0.
  - sram_io is high-Z.
  - On the last cycle, capture sram_io into rdata[15:0] (LO) or rdata[31:16] (HI).
  - Reads always perform both halves.
- Write phase:
  - sram_oe_n = 1 throughout.
  - sram_io drives wdata[15:0] (LO) or wdata[31:16] (HI) for the whole phase.
  - ble_n/bhe_n = ~wstrb[0]/~wstrb[1] (LO) or ~wstrb[2]/~wstrb[3] (HI).
  - sram_we_n = 0 only in the last cycle of the phase; the SRAM commits at the following posedge.
- Transitions:
  - LO -> HI if read, or if write with wstrb[3:2] != 0; otherwise LO -> DONE.
  - HI -> DONE.
- DONE:
  - ack = 1 for exactly one cycle; all SRAM strobes deasserted; sram_io high-Z.
  - Next state is IDLE.
  - This gives a guaranteed bus-turnaround cycle between any write and a subsequent read.
- Latency from the req-accept edge to ack, with WAIT_CYCLES = 0:
  - Full read or write: 3 cycles.
  - Single-half write: 2 cycles.
  - Zero-strobe write: 1 cycle.
  - General case: +WAIT_CYCLES per executed half.
- Back-to-back requests:
  - req held high in DONE is ignored.
  - A new request is accepted in the IDLE cycle after ack; maximum one request per (latency + 1) cycles.
- Inputs are not sampled while busy; changes to addr/wdata mid-transaction have no effect.
- rdata is updated only by reads; writes leave it unchanged.
- Misaligned addr[1:0] is silently dropped.
- Contention rule: sram_io is never driven while sram_oe_n = 0. Assert this in the bench.

Decomposition:
- Package sram_ctrl_pkg holds:
  - The state enum (IDLE, LO, HI, DONE).
  - HALF_LO = 1'b0 and HALF_HI = 1'b1.
  - The SRAM address width constant 16.
- No sub-module is needed; the tri-state driver and wait counter stay inline in sram_ctrl.

Test Plan:
- Write addr=0x00010, wdata=0xDEADBEEF, wstrb=4'hF, then read the same address:
  - Required: SRAM halfword 0x0008 = 0xBEEF and 0x0009 = 0xDEAD.
  - Required: read ack 3 cycles after accept, rdata = 0xDEADBEEF.
- Byte-strobe merge:
  - Preload 0x11223344 at 0x00020, then write 0xAABBCCDD with wstrb=4'b0100.
  - Required: 2-cycle latency, LO phase skipped, bhe_n=1 / ble_n=0 during HI.
  - Required: readback = 0x11BB3344.
- Zero-strobe write at 0x00030:
  - Required: ack 1 cycle after accept; sram_ce_n stays 1 throughout; memory unchanged.
- WAIT_CYCLES=2, read at 0x1FFFC (top word):
  - Required: sram_a = 0xFFFE then 0xFFFF, each held 3 cycles.
  - Required: ack at cycle 7; correct data.
- Assert rst during HI of a full write:
  - Required: all strobes high and sram_io high-Z immediately (asynchronously); no ack.
  - Required: the low half remains written, the high half is unchanged.
  - Required: the next request completes normally.
- Back-to-back write then read with req held high continuously:
  - Required: second accept occurs exactly 1 cycle after the first ack.
  - Required: no cycle has sram_oe_n = 0 while sram_io is driven.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit bus to 16-bit async SRAM controller.
package sram_ctrl_pkg;

  // Halfword address width of the 64K x 16 SRAM.
  localparam int unsigned SramAddrW = 16;

  // Half selector appended as the SRAM address LSB.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Splits 32-bit bus requests into two sequenced 16-bit async SRAM accesses
// (low half, then high half) and returns a one-cycle ack with assembled read data.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  output logic [31:0]          rdata,
  output logic                 ack,
  output logic                 busy,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ble_n,
  output logic                 sram_bhe_n,
  output logic [SramAddrW-1:0] sram_a,
  inout  wire  [15:0]          sram_io
);

  localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [ADDR_W-3:0] word_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              phase;
  logic              half;
  logic              last;
  logic              io_en;
  logic [15:0]       io_out;

  // Byte offset within the word is dropped on purpose.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign accept = (state_q == StIdle) && req;
  assign phase  = (state_q == StLo) || (state_q == StHi);
  assign half   = (state_q == StHi) ? HALF_HI : HALF_LO;
  assign last   = (cnt_q == WaitLast);

  // Next state and wait counter; halves with no enabled strobes are skipped on writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req) begin
          if (!wr || (|wstrb[1:0]))  state_d = StLo;
          else if (|wstrb[3:2])      state_d = StHi;
          else                       state_d = StDone;
        end
      end
      StLo: begin
        if (last) begin
          cnt_d   = '0;
          state_d = (!wr_q || (|wstrb_q[3:2])) ? StHi : StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHi: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture; inputs are ignored while a transaction is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      wr_q    <= wr;
      word_q  <= addr[ADDR_W-1:2];
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Read data is sampled on the last cycle of each read half; writes leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (phase && !wr_q && last) begin
      if (half == HALF_HI) rdata_q[31:16] <= sram_io;
      else                 rdata_q[15:0]  <= sram_io;
    end
  end

  // SRAM pin decode; WE pulses only in the final cycle of a write half so
  // address and data have settled for the whole setup window.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ble_n = 1'b1;
    sram_bhe_n = 1'b1;
    sram_a     = '0;
    io_en      = 1'b0;
    io_out     = '0;
    if (phase) begin
      sram_ce_n = 1'b0;
      sram_a    = SramAddrW'({word_q, half});
      if (wr_q) begin
        io_en      = 1'b1;
        io_out     = (half == HALF_HI) ? wdata_q[31:16] : wdata_q[15:0];
        sram_ble_n = (half == HALF_HI) ? ~wstrb_q[2] : ~wstrb_q[0];
        sram_bhe_n = (half == HALF_HI) ? ~wstrb_q[3] : ~wstrb_q[1];
        sram_we_n  = ~last;
      end else begin
        sram_oe_n  = 1'b0;
        sram_ble_n = 1'b0;
        sram_bhe_n = 1'b0;
      end
    end
  end

  assign sram_io = io_en ? io_out : {16{1'bz}};
  assign ack     = (state_q == StDone);
  assign busy    = (state_q != StIdle);
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: two controllers (WAIT_CYCLES 0 and 2), each with
// a behavioural 64K x 16 async SRAM model on its bus.
module tb_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic        wr;
  logic [16:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1, busy0, busy1;
  logic        ce_n0, oe_n0, we_n0, ble_n0, bhe_n0;
  logic        ce_n1, oe_n1, we_n1, ble_n1, bhe_n1;
  logic [15:0] a0, a1;
  wire  [15:0] io0, io1;

  int vectors;
  int miscompares;

  logic [15:0] mem0 [65536];
  logic [15:0] mem1 [65536];
  bit          mem_ready = 1'b0;

  // Per-cycle pin trace captured by run_req, index 0 = first cycle after accept.
  logic [15:0] tr_a   [64];
  logic        tr_ce  [64];
  logic        tr_oe  [64];
  logic        tr_we  [64];
  logic        tr_ble [64];
  logic        tr_bhe [64];

  sram_ctrl #(.WAIT_CYCLES(0), .ADDR_W(17)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr(wr), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
    .sram_we_n(we_n0), .sram_ble_n(ble_n0), .sram_bhe_n(bhe_n0), .sram_a(a0), .sram_io(io0)
  );

  sram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(17)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1),
    .sram_we_n(we_n1), .sram_ble_n(ble_n1), .sram_bhe_n(bhe_n1), .sram_a(a1), .sram_io(io1)
  );

  pullup (io0);
  pullup (io1);

  // SRAM models: drive on read, commit byte lanes at the posedge while WE is low.
  assign io0 = (!ce_n0 && !oe_n0 && we_n0) ? mem0[a0] : {16{1'bz}};
  assign io1 = (!ce_n1 && !oe_n1 && we_n1) ? mem1[a1] : {16{1'bz}};

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) begin
        mem0[i] <= 16'(i) ^ 16'hA5A5;
        mem1[i] <= 16'(i) ^ 16'hA5A5;
      end
      mem_ready <= 1'b1;
    end else begin
      if (!ce_n0 && !we_n0) begin
        if (!ble_n0) mem0[a0][7:0]  <= io0[7:0];
        if (!bhe_n0) mem0[a0][15:8] <= io0[15:8];
      end
      if (!ce_n1 && !we_n1) begin
        if (!ble_n1) mem1[a1][7:0]  <= io1[7:0];
        if (!bhe_n1) mem1[a1][15:8] <= io1[15:8];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus contention watch: while OE is low only the SRAM may drive, so the bus must
  // carry exactly the model's data; in idle/ack cycles the controller must release it.
  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (!oe_n0) begin
        vectors++;
        if (we_n0 !== 1'b1 || ce_n0 !== 1'b0 || io0 !== mem0[a0]) begin
          miscompares++;
          $display("FAIL contention0: io=%h we_n=%b ce_n=%b, required io=%h we_n=1 ce_n=0",
                   io0, we_n0, ce_n0, mem0[a0]);
        end
      end
      if (!oe_n1) begin
        vectors++;
        if (we_n1 !== 1'b1 || ce_n1 !== 1'b0 || io1 !== mem1[a1]) begin
          miscompares++;
          $display("FAIL contention1: io=%h we_n=%b ce_n=%b, required io=%h we_n=1 ce_n=0",
                   io1, we_n1, ce_n1, mem1[a1]);
        end
      end
      if (!busy0 || ack0) begin
        vectors++;
        if (!(io0 === 16'hzzzz || io0 === 16'hffff || io0 === 16'h0000)) begin
          miscompares++;
          $display("FAIL release0: io=%h while idle/ack, required high-Z", io0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request and trace pins each cycle until ack; lat = -1 on timeout.
  task automatic run_req(input bit sel, input bit w, input logic [16:0] ad,
                         input logic [31:0] wd, input logic [3:0] ws, output int lat);
    @(negedge clk);
    wr = w; addr = ad; wdata = wd; wstrb = ws;
    if (sel) req1 = 1'b1;
    else     req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tr_a[c-1]   = sel ? a1 : a0;
      tr_ce[c-1]  = sel ? ce_n1 : ce_n0;
      tr_oe[c-1]  = sel ? oe_n1 : oe_n0;
      tr_we[c-1]  = sel ? we_n1 : we_n0;
      tr_ble[c-1] = sel ? ble_n1 : ble_n0;
      tr_bhe[c-1] = sel ? bhe_n1 : bhe_n0;
      if (sel ? ack1 : ack0) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; wr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy0, ack0} !== 2'b00) begin
      miscompares++; $display("FAIL reset_busy_ack: %b, required 00", {busy0, ack0});
    end
    vectors++;
    if (rdata0 !== 32'h0) begin
      miscompares++; $display("FAIL reset_rdata: %h, required 00000000", rdata0);
    end
    vectors++;
    if ({ce_n0, oe_n0, we_n0, ble_n0, bhe_n0} !== 5'b11111) begin
      miscompares++;
      $display("FAIL reset_strobes: %b, required 11111", {ce_n0, oe_n0, we_n0, ble_n0, bhe_n0});
    end
    vectors++;
    if (a0 !== 16'h0000) begin
      miscompares++; $display("FAIL reset_addr: %h, required 0000", a0);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_write_read;
    int lat;
    run_req(1'b0, 1'b1, 17'h00010, 32'hDEADBEEF, 4'hF, lat);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL full_wr_lat: %0d, required 3", lat); end
    vectors++;
    if ({tr_a[0], tr_a[1]} !== {16'h0008, 16'h0009}) begin
      miscompares++; $display("FAIL full_wr_addr: %h %h, required 0008 0009", tr_a[0], tr_a[1]);
    end
    vectors++;
    if ({tr_we[0], tr_we[1], tr_oe[0], tr_oe[1]} !== 4'b0011) begin
      miscompares++;
      $display("FAIL full_wr_we_oe: %b, required 0011",
               {tr_we[0], tr_we[1], tr_oe[0], tr_oe[1]});
    end
    vectors++;
    if ({mem0[16'h0009], mem0[16'h0008]} !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL full_wr_mem: %h%h, required DEADBEEF", mem0[16'h0009], mem0[16'h0008]);
    end
    run_req(1'b0, 1'b0, 17'h00010, 32'h0, 4'h0, lat);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL full_rd_lat: %0d, required 3", lat); end
    vectors++;
    if (rdata0 !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL full_rd_data: %h, required DEADBEEF", rdata0);
    end
  endtask

  task automatic test_strobe_merge;
    int lat;
    run_req(1'b0, 1'b1, 17'h00020, 32'h11223344, 4'hF, lat);
    run_req(1'b0, 1'b1, 17'h00020, 32'hAABBCCDD, 4'b0100, lat);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL merge_lat: %0d, required 2", lat); end
    vectors++;
    if (tr_a[0] !== 16'h0011 || tr_ce[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL merge_skip_lo: a=%h ce_n=%b, required a=0011 ce_n=0", tr_a[0], tr_ce[0]);
    end
    vectors++;
    if ({tr_bhe[0], tr_ble[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL merge_lanes: bhe_n/ble_n=%b%b, required 10", tr_bhe[0], tr_ble[0]);
    end
    run_req(1'b0, 1'b0, 17'h00020, 32'h0, 4'h0, lat);
    vectors++;
    if (rdata0 !== 32'h11BB3344) begin
      miscompares++; $display("FAIL merge_rd: %h, required 11BB3344", rdata0);
    end
  endtask

  task automatic test_zero_strobe;
    int lat;
    run_req(1'b0, 1'b1, 17'h00030, 32'h12345678, 4'h0, lat);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL zero_lat: %0d, required 1", lat); end
    vectors++;
    if (tr_ce[0] !== 1'b1) begin
      miscompares++; $display("FAIL zero_ce: ce_n=%b, required 1", tr_ce[0]);
    end
    vectors++;
    if ({mem0[16'h0019], mem0[16'h0018]} !== 32'hA5BCA5BD) begin
      miscompares++;
      $display("FAIL zero_mem: %h%h, required A5BCA5BD", mem0[16'h0019], mem0[16'h0018]);
    end
    vectors++;
    if (rdata0 !== 32'h11BB3344) begin
      miscompares++; $display("FAIL zero_rdata_hold: %h, required 11BB3344", rdata0);
    end
  endtask

  task automatic test_wait_states;
    int lat;
    run_req(1'b1, 1'b1, 17'h00004, 32'h01234567, 4'hF, lat);
    vectors++;
    if (lat !== 7) begin miscompares++; $display("FAIL wait_wr_lat: %0d, required 7", lat); end
    vectors++;
    if ({tr_we[0], tr_we[1], tr_we[2], tr_we[3], tr_we[4], tr_we[5]} !== 6'b110110) begin
      miscompares++;
      $display("FAIL wait_we_pulse: %b, required 110110",
               {tr_we[0], tr_we[1], tr_we[2], tr_we[3], tr_we[4], tr_we[5]});
    end
    vectors++;
    if ({mem1[16'h0003], mem1[16'h0002]} !== 32'h01234567) begin
      miscompares++;
      $display("FAIL wait_wr_mem: %h%h, required 01234567", mem1[16'h0003], mem1[16'h0002]);
    end
    run_req(1'b1, 1'b0, 17'h1FFFC, 32'h0, 4'h0, lat);
    vectors++;
    if (lat !== 7) begin miscompares++; $display("FAIL wait_rd_lat: %0d, required 7", lat); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (tr_a[i] !== ((i < 3) ? 16'hFFFE : 16'hFFFF)) begin
        miscompares++;
        $display("FAIL wait_rd_addr[%0d]: %h, required %h", i, tr_a[i],
                 (i < 3) ? 16'hFFFE : 16'hFFFF);
      end
    end
    vectors++;
    if (rdata1 !== 32'h5A5A5A5B) begin
      miscompares++; $display("FAIL wait_rd_data: %h, required 5A5A5A5B", rdata1);
    end
  endtask

  task automatic test_reset_mid_write;
    int lat;
    int acks;
    @(negedge clk);
    wr = 1'b1; addr = 17'h00040; wdata = 32'hCAFEF00D; wstrb = 4'hF; req0 = 1'b1;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({ce_n0, we_n0, a0} !== {2'b00, 16'h0021}) begin
      miscompares++;
      $display("FAIL rst_pre_hi: ce_n=%b we_n=%b a=%h, required 0 0 0021", ce_n0, we_n0, a0);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({ce_n0, oe_n0, we_n0, ble_n0, bhe_n0} !== 5'b11111) begin
      miscompares++;
      $display("FAIL rst_async_strobes: %b, required 11111", {ce_n0, oe_n0, we_n0, ble_n0, bhe_n0});
    end
    vectors++;
    if (!(io0 === 16'hzzzz || io0 === 16'hffff || io0 === 16'h0000)) begin
      miscompares++; $display("FAIL rst_async_io: %h, required high-Z", io0);
    end
    acks = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    rst = 1'b0;
    vectors++;
    if (acks !== 0) begin miscompares++; $display("FAIL rst_no_ack: %0d acks, required 0", acks); end
    vectors++;
    if ({mem0[16'h0021], mem0[16'h0020]} !== 32'hA584F00D) begin
      miscompares++;
      $display("FAIL rst_partial: %h%h, required A584F00D", mem0[16'h0021], mem0[16'h0020]);
    end
    run_req(1'b0, 1'b0, 17'h00040, 32'h0, 4'h0, lat);
    vectors++;
    if (lat !== 3 || rdata0 !== 32'hA584F00D) begin
      miscompares++;
      $display("FAIL rst_recover: lat=%0d rdata=%h, required 3 A584F00D", lat, rdata0);
    end
  endtask

  task automatic test_back_to_back;
    int c1;
    @(negedge clk);
    wr = 1'b1; addr = 17'h00050; wdata = 32'h13579BDF; wstrb = 4'hF; req0 = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    c1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack0) begin c1 = c; break; end
    end
    vectors++;
    if (c1 !== 3) begin miscompares++; $display("FAIL b2b_wr_lat: %0d, required 3", c1); end
    @(negedge clk);
    vectors++;
    if ({busy0, ack0} !== 2'b00) begin
      miscompares++; $display("FAIL b2b_idle_gap: busy/ack=%b%b, required 00", busy0, ack0);
    end
    @(negedge clk);
    req0 = 1'b0;
    vectors++;
    if ({busy0, oe_n0, a0} !== {2'b10, 16'h0028}) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b oe_n=%b a=%h, required 1 0 0028", busy0, oe_n0, a0);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ack0 !== 1'b1 || rdata0 !== 32'h13579BDF) begin
      miscompares++;
      $display("FAIL b2b_rd: ack=%b rdata=%h, required 1 13579BDF", ack0, rdata0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_write_read();
    test_strobe_merge();
    test_zero_strobe();
    test_wait_states();
    test_reset_mid_write();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
